sdram_read_streamer: RTL and testbench



---
 rtl/sdram_stream_pkg.sv | 23 ++
 rtl/sdram_stream_fifo.sv | 70 +++++++
 rtl/sdram_read_streamer.sv | 195 +++++++++++++++++++
 tb/tb_sdram_read_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_stream_pkg.sv
// Shared types and constants for the SDRAM read streamer.
package sdram_stream_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

    // Fixed fields of every read command pushed to the controller
    localparam logic              CMD_IS_WRITE   = 1'b0;
    localparam logic [1:0]        CMD_WRITE_MASK = 2'b11;
    localparam logic [DATA_W-1:0] CMD_WRITE_DATA = '0;

    // Word address increment, wrapping modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sdram_stream_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on dout whenever
// the FIFO is non-empty, so a word pushed on one edge is presented the
// very next cycle. Push and pop together are legal at any occupancy.
module sdram_stream_fifo
    import sdram_stream_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // Pop on empty is dropped; push on full only lands if a pop frees the slot
    always_comb begin
        do_pop  = pop & (count_reg != '0);
        do_push = push & ((count_reg != FULL_COUNT) | do_pop);
    end

    // Storage array, no reset needed on the data itself
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;

endmodule

// File: rtl/sdram_read_streamer.sv
// Streams a (base, length) block out of SDRAM: issues sequential read
// commands into the controller command FIFO, bounded by a credit count so
// that every read in flight is guaranteed a slot in the response FIFO, and
// presents the returned words as a valid/ready stream.
module sdram_read_streamer
    import sdram_stream_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LEN_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              cmdWrite,
    input  logic              cmdFull,
    output logic              cmdIsWrite,
    output logic [ADDR_W-1:0] cmdAddress,
    output logic [1:0]        cmdWriteMask,
    output logic [DATA_W-1:0] cmdWriteData,
    input  logic              readValid,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    output logic              seqError
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    stream_state_t     state_reg;
    stream_state_t     state_next;
    logic [ADDR_W-1:0] issue_addr_reg;
    logic [ADDR_W-1:0] exp_addr_reg;
    logic [LEN_W-1:0]  issue_left_reg;
    logic [LEN_W-1:0]  pop_left_reg;
    logic [CW-1:0]     outstanding_reg;
    logic              seq_error_reg;
    logic              zero_done_reg;

    logic              start_ok;
    logic              capture;
    logic              pop;
    logic              last_pop;
    logic              error_now;
    logic [CW-1:0]     credits;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;

    // Credits are whatever the response FIFO could still absorb once every
    // read in flight has landed; issuing only with a credit in hand means
    // the FIFO never overflows even though the read port has no backpressure.
    always_comb begin
        start_ok  = (state_reg == IDLE) & start;
        credits   = CREDIT_MAX - outstanding_reg - fifo_count;
        capture   = readValid & (state_reg != IDLE) & (outstanding_reg != '0);
        pop       = ~fifo_empty & outReady;
        last_pop  = pop & (pop_left_reg == LEN_W'(1));
        error_now = (readValid & ((state_reg == IDLE) | (outstanding_reg == '0)))
                  | (capture & (raddr != exp_addr_reg))
                  | (capture & fifo_full & ~pop);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and command strobe
    always_comb begin
        state_next = state_reg;
        cmdWrite   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start_ok && (length != '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cmdWrite = (credits != '0) & ~cmdFull;
                if (cmdWrite && (issue_left_reg == LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue-side address and remaining-count tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_addr_reg <= '0;
            issue_left_reg <= '0;
        end else if (start_ok) begin
            issue_addr_reg <= baseAddr;
            issue_left_reg <= length;
        end else if (cmdWrite) begin
            issue_addr_reg <= addr_inc(issue_addr_reg);
            issue_left_reg <= issue_left_reg - LEN_W'(1);
        end
    end

    // Return-side expected address and words still to deliver
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_addr_reg <= '0;
            pop_left_reg <= '0;
        end else if (start_ok) begin
            exp_addr_reg <= baseAddr;
            pop_left_reg <= length;
        end else begin
            if (capture) begin
                exp_addr_reg <= addr_inc(exp_addr_reg);
            end
            if (pop) begin
                pop_left_reg <= pop_left_reg - LEN_W'(1);
            end
        end
    end

    // Reads issued but not yet returned
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_reg <= '0;
        end else begin
            unique case ({cmdWrite, capture})
                2'b10:   outstanding_reg <= outstanding_reg + CW'(1);
                2'b01:   outstanding_reg <= outstanding_reg - CW'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Sticky sequencing error; a fresh error in the start cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_error_reg <= 1'b0;
        end else if (error_now) begin
            seq_error_reg <= 1'b1;
        end else if (start_ok) begin
            seq_error_reg <= 1'b0;
        end
    end

    // Zero-length requests complete immediately with a delayed done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_done_reg <= 1'b0;
        end else begin
            zero_done_reg <= start_ok & (length == '0);
        end
    end

    sdram_stream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (rdata),
        .pop   (pop),
        .dout  (outData),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign busy         = (state_reg != IDLE);
    assign done         = zero_done_reg | last_pop;
    assign cmdIsWrite   = CMD_IS_WRITE;
    assign cmdAddress   = issue_addr_reg;
    assign cmdWriteMask = CMD_WRITE_MASK;
    assign cmdWriteData = CMD_WRITE_DATA;
    assign outValid     = ~fifo_empty;
    assign outLast      = ~fifo_empty & (pop_left_reg == LEN_W'(1));
    assign seqError     = seq_error_reg;

endmodule

// File: tb/tb_sdram_read_streamer.sv
// Randomized bench for sdram_read_streamer with a behavioural SDRAM
// controller model (in-order returns after a fixed latency) and a
// reference stream computed directly from the request parameters.
module tb_sdram_read_streamer;

    localparam int DEPTH = 64;
    localparam int LEN_W = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [24:0]       baseAddr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              cmdWrite;
    logic              cmdFull;
    logic              cmdIsWrite;
    logic [24:0]       cmdAddress;
    logic [1:0]        cmdWriteMask;
    logic [15:0]       cmdWriteData;
    logic              readValid;
    logic [24:0]       raddr;
    logic [15:0]       rdata;
    logic              outValid;
    logic              outReady;
    logic [15:0]       outData;
    logic              outLast;
    logic              seqError;

    sdram_read_streamer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .baseAddr     (baseAddr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .cmdWrite     (cmdWrite),
        .cmdFull      (cmdFull),
        .cmdIsWrite   (cmdIsWrite),
        .cmdAddress   (cmdAddress),
        .cmdWriteMask (cmdWriteMask),
        .cmdWriteData (cmdWriteData),
        .readValid    (readValid),
        .raddr        (raddr),
        .rdata        (rdata),
        .outValid     (outValid),
        .outReady     (outReady),
        .outData      (outData),
        .outLast      (outLast),
        .seqError     (seqError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        int          due;
        int          idx;
    } rd_t;

    rd_t         pend[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] salt     = 16'h0;
    bit          aborted;

    // Expected memory content at a word address
    function automatic logic [15:0] data_of(input logic [24:0] a);
        return a[15:0] ^ {7'd0, a[24:16]} ^ salt;
    endfunction

    task automatic drive_idle();
        start     = 1'b0;
        baseAddr  = '0;
        length    = '0;
        cmdFull   = 1'b0;
        readValid = 1'b0;
        raddr     = '0;
        rdata     = '0;
        outReady  = 1'b1;
    endtask

    // Runs one request end to end against the controller model.
    // hold: cycles outReady is forced low; full_at: first cycle of a
    // 10-cycle cmdFull window; bad_idx: word whose raddr is corrupted;
    // rst_at: stop after this many pops (leaves the request unfinished).
    task automatic run_stream(input string name, input logic [24:0] base, input int len,
                              input int lat, input int hold, input int full_at,
                              input int bad_idx, input bit rand_ready, input int rst_at);
        int          issued = 0;
        int          popped = 0;
        int          cyc = 0;
        int          budget;
        bit          finished = 0;
        bit          exp_busy = 0;
        bit          do_pop;
        bit          exp_err;
        logic [24:0] ea;
        rd_t         p;
        budget  = 4 * len + hold + lat + 200;
        aborted = 0;
        salt    = 16'($urandom);
        pend.delete();
        while (!finished && cyc < budget) begin
            @(negedge clk);
            start     = (cyc == 0);
            baseAddr  = base;
            length    = LEN_W'(len);
            cmdFull   = (full_at >= 0) && (cyc >= full_at) && (cyc < full_at + 10);
            outReady  = (cyc < hold) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            readValid = 1'b0;
            raddr     = '0;
            rdata     = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p         = pend.pop_front();
                readValid = 1'b1;
                raddr     = (p.idx == bad_idx) ? (p.addr ^ 25'd1) : p.addr;
                rdata     = data_of(p.addr);
            end
            #1;
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL %s_busy cyc=%0d: got %b expected %b", name, cyc, busy, exp_busy);
            end
            if (cmdFull) begin
                checks++;
                if (cmdWrite !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_cmd_while_full cyc=%0d: got %b expected 0", name, cyc, cmdWrite);
                end
            end
            if (cmdWrite === 1'b1) begin
                ea = base + 25'(issued);
                checks++;
                if (issued >= len || cmdAddress !== ea) begin
                    failures++;
                    $display("FAIL %s_cmd_addr #%0d: got %h expected %h (len %0d)",
                             name, issued, cmdAddress, ea, len);
                end
                pend.push_back('{addr: ea, due: cyc + lat, idx: issued});
                issued++;
                checks++;
                if (issued - popped > DEPTH) begin
                    failures++;
                    $display("FAIL %s_inflight cyc=%0d: got %0d expected <= %0d",
                             name, cyc, issued - popped, DEPTH);
                end
            end
            do_pop = (outValid === 1'b1) && outReady;
            if (do_pop) begin
                ea = base + 25'(popped);
                checks++;
                if (outData !== data_of(ea)) begin
                    failures++;
                    $display("FAIL %s_data #%0d: got %h expected %h", name, popped, outData, data_of(ea));
                end
                checks++;
                if (outLast !== (popped == len - 1)) begin
                    failures++;
                    $display("FAIL %s_last #%0d: got %b expected %b", name, popped, outLast, popped == len - 1);
                end
            end
            checks++;
            if (done !== (do_pop && popped == len - 1)) begin
                failures++;
                $display("FAIL %s_done cyc=%0d: got %b expected %b", name, cyc, done, do_pop && popped == len - 1);
            end
            if (hold > 0 && cyc == hold - 1) begin
                checks++;
                if (issued != ((len < DEPTH) ? len : DEPTH)) begin
                    failures++;
                    $display("FAIL %s_credit_limit: got %0d issued expected %0d",
                             name, issued, (len < DEPTH) ? len : DEPTH);
                end
            end
            if (cyc == 0) exp_busy = 1;
            if (do_pop) begin
                popped++;
                if (popped == len) begin
                    exp_busy = 0;
                    finished = 1;
                end
                if (rst_at > 0 && popped == rst_at) begin
                    aborted  = 1;
                    finished = 1;
                end
            end
            cyc++;
        end
        if (!finished) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, popped, len);
        end
        if (!aborted) begin
            @(negedge clk);
            drive_idle();
            #1;
            exp_err = (bad_idx >= 0) && (bad_idx < len);
            checks++;
            if (busy !== 1'b0 || outValid !== 1'b0 || issued != len) begin
                failures++;
                $display("FAIL %s_end: got busy=%b outValid=%b issued=%0d expected 0 0 %0d",
                         name, busy, outValid, issued, len);
            end
            checks++;
            if (seqError !== exp_err) begin
                failures++;
                $display("FAIL %s_seqerr: got %b expected %b", name, seqError, exp_err);
            end
        end
        $display("txn %s base=%h len=%0d issued=%0d popped=%0d", name, base, len, issued, popped);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, cmdWrite, outValid, outLast, seqError} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {busy, done, cmdWrite, outValid, outLast, seqError});
        end
        checks++;
        if (cmdIsWrite !== 1'b0 || cmdWriteMask !== 2'b11 || cmdWriteData !== 16'h0) begin
            failures++;
            $display("FAIL reset_cmd_consts: got %b %b %h expected 0 11 0000",
                     cmdIsWrite, cmdWriteMask, cmdWriteData);
        end
        $display("txn reset");
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        start    = 1'b1;
        baseAddr = 25'(($urandom));
        length   = '0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmdWrite !== 1'b0) begin
            failures++;
            $display("FAIL zero_start_cycle: got done=%b busy=%b cmd=%b expected 0 0 0", done, busy, cmdWrite);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cmdWrite !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%b busy=%b cmd=%b expected 1 0 0", done, busy, cmdWrite);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
        end
        $display("txn zero_length");
    endtask

    task automatic test_basic_stream();
        run_stream("basic", 25'h0, 8, 3, 0, -1, -1, 1'b0, -1);
    endtask

    task automatic test_random_streams();
        for (int i = 0; i < 4; i++) begin
            run_stream("random", 25'($urandom), $urandom_range(1, 90), $urandom_range(2, 7),
                       0, -1, -1, 1'b1, -1);
        end
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 25'($urandom), 200, 3, 150, -1, -1, 1'b0, -1);
    endtask

    task automatic test_cmd_full();
        run_stream("cmd_full", 25'($urandom), 30, 4, 0, 8, -1, 1'b0, -1);
    endtask

    task automatic test_wrap_error();
        run_stream("wrap_error", 25'h1FFFFFE, 4, 3, 0, -1, 2, 1'b0, -1);
    endtask

    task automatic test_stray_idle();
        checks++;
        if (seqError !== 1'b1) begin
            failures++;
            $display("FAIL stray_pre: got %b expected 1 (left from wrap test)", seqError);
        end
        run_stream("clean", 25'($urandom), 5, 2, 0, -1, -1, 1'b0, -1);
        @(negedge clk);
        readValid = 1'b1;
        raddr     = 25'($urandom);
        rdata     = 16'($urandom);
        @(negedge clk);
        readValid = 1'b0;
        #1;
        checks++;
        if (seqError !== 1'b1 || busy !== 1'b0 || outValid !== 1'b0) begin
            failures++;
            $display("FAIL stray_idle: got seqErr=%b busy=%b outValid=%b expected 1 0 0",
                     seqError, busy, outValid);
        end
        $display("txn stray_idle");
    endtask

    task automatic test_reset_mid_stream();
        run_stream("rst_mid", 25'($urandom), 20, 4, 0, -1, -1, 1'b0, 5);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        #1;
        checks++;
        if (outValid !== 1'b0 || busy !== 1'b0 || cmdWrite !== 1'b0 || seqError !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state: got outValid=%b busy=%b cmd=%b err=%b expected 0 0 0 0",
                     outValid, busy, cmdWrite, seqError);
        end
        $display("txn rst_mid reset applied");
        run_stream("after_rst", 25'($urandom), 100, 5, 120, -1, -1, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_zero_length();
        test_basic_stream();
        test_random_streams();
        test_backpressure();
        test_cmd_full();
        test_wrap_error();
        test_stray_idle();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
